// File: rtl/alu_shift_unit.sv
// alu_shift_unit: single-cycle ALU plus bit-serial shifter (one bit per cycle).
// Optional feature: define ALU_SHIFT_ROTATE_EN to build rol/ror (opcodes 1011/1100);
// without it those opcodes behave as undefined opcodes (result 0).
module alu_shift_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       opCode,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             zero,
  output logic             carry
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       r_state;
  logic [3:0]       r_op;
  logic [SHW-1:0]   r_count;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_carry;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_alu;
  logic             w_alu_carry;
  logic             w_is_shift;
  logic [SHW-1:0]   w_amt;
  logic [WIDTH-1:0] w_step;

  assign w_sum  = {1'b0, rs} + {1'b0, rt};
  assign w_diff = {1'b0, rs} - {1'b0, rt};
  assign w_amt  = rt[SHW-1:0];

  // Single-cycle ALU result and carry/borrow for the operation being accepted
  always_comb begin
    w_alu       = '0;
    w_alu_carry = 1'b0;
    case (opCode)
      4'b0001: begin w_alu = w_sum[WIDTH-1:0];  w_alu_carry = w_sum[WIDTH];  end
      4'b0010: begin w_alu = w_diff[WIDTH-1:0]; w_alu_carry = w_diff[WIDTH]; end
      4'b0011: w_alu = rs & rt;
      4'b0100: w_alu = rs | rt;
      4'b0101: w_alu = ~rs;
      4'b0110: w_alu = rs ^ rt;
      default: w_alu = '0;
    endcase
  end

  // Classify the incoming opcode as a multi-cycle shift/rotate
  always_comb begin
    case (opCode)
      4'b1000, 4'b1001, 4'b1010: w_is_shift = 1'b1;
`ifdef ALU_SHIFT_ROTATE_EN
      4'b1011, 4'b1100:          w_is_shift = 1'b1;
`endif
      default:                   w_is_shift = 1'b0;
    endcase
  end

  // One-bit shift/rotate of the working result for the captured opcode
  always_comb begin
    case (r_op)
      4'b1000: w_step = {r_result[WIDTH-2:0], 1'b0};
      4'b1001: w_step = {1'b0, r_result[WIDTH-1:1]};
      4'b1010: w_step = {r_result[WIDTH-1], r_result[WIDTH-1:1]};
`ifdef ALU_SHIFT_ROTATE_EN
      4'b1011: w_step = {r_result[WIDTH-2:0], r_result[WIDTH-1]};
      4'b1100: w_step = {r_result[0], r_result[WIDTH-1:1]};
`endif
      default: w_step = r_result;
    endcase
  end

  // Control FSM and result/flag registers; flags always track the value written to result
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_op     <= '0;
      r_count  <= '0;
      r_result <= '0;
      r_zero   <= 1'b1;
      r_carry  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_op <= opCode;
            if (w_is_shift) begin
              r_result <= rs;
              r_zero   <= (rs == '0);
              r_carry  <= 1'b0;
              r_count  <= w_amt;
              r_state  <= (w_amt == '0) ? DONE : SHIFT;
            end else begin
              r_result <= w_alu;
              r_zero   <= (w_alu == '0);
              r_carry  <= w_alu_carry;
              r_state  <= DONE;
            end
          end
        end
        SHIFT: begin
          r_result <= w_step;
          r_zero   <= (w_step == '0);
          r_count  <= r_count - SHW'(1);
          if (r_count == SHW'(1)) r_state <= DONE;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign result = r_result;
  assign zero   = r_zero;
  assign carry  = r_carry;
  assign busy   = (r_state != IDLE);
  assign done   = (r_state == DONE);

endmodule

// File: doc/alu_shift_unit.md
ALU_SHIFT_UNIT -- requirements
Module: alu_shift_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (legal: 8, 16, 32, 64).
REQ-002 SHALL have parameter SHW, default 5, shift-amount width; SHW = log2(WIDTH).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-006 SHALL have port opCode  input  4  operation select, per REQ-011.
REQ-007 SHALL have port rs  input  WIDTH  first operand / shift source.
REQ-008 SHALL have port rt  input  WIDTH  second operand; shift amount = rt[SHW-1:0].
REQ-009 SHALL have port result  output  WIDTH, port busy  output  1, port done  output  1, port zero  output  1, port carry  output  1.

Function
REQ-010 SHALL implement FSM states IDLE, SHIFT, DONE; busy = (state != IDLE); done = (state == DONE).
REQ-011 Opcodes: 0000 zero; 0001 rs+rt; 0010 rs-rt; 0011 rs&rt; 0100 rs|rt; 0101 ~rs; 0110 rs^rt; 1000 sll; 1001 srl; 1010 sra; 1011 rol; 1100 ror; all others yield result 0.
REQ-012 IDLE with start=1: rs, rt, opCode SHALL be captured; start in SHIFT or DONE SHALL be ignored.
REQ-013 Non-shift opcode: result, zero, carry SHALL register on the accepting edge; FSM -> DONE; done high exactly 1 cycle after start accepted.
REQ-014 Shift opcode, amount k = 0: result = rs, FSM -> DONE; same latency as REQ-013.
REQ-015 Shift opcode, k > 0: result loads rs, counter loads k, FSM -> SHIFT; each SHIFT cycle shifts/rotates result by one bit and decrements counter; on counter 1 -> DONE; done high k+1 cycles after start accepted.
REQ-016 sll/srl SHALL fill with 0; sra SHALL fill with result[WIDTH-1]; rol/ror SHALL circulate the exiting bit.
REQ-017 DONE SHALL last exactly one cycle, then IDLE; a start coincident with done SHALL be ignored.
REQ-018 Arithmetic modulo 2^WIDTH; carry = carry-out for add, borrow (rs < rt unsigned) for sub, 0 for all other ops.
REQ-019 zero SHALL equal (result == 0), updated in the same cycle as result.
REQ-020 result, zero, carry SHALL hold from DONE until the next accepted start.

Reset
REQ-021 reset=1 at a clock edge SHALL force state IDLE, result 0, zero 1, carry 0, counter 0, busy 0, done 0.
REQ-022 reset SHALL take priority over start and over any in-progress SHIFT; an aborted operation SHALL produce no done pulse.

Configuration
REQ-023 Macro ALU_SHIFT_ROTATE_EN: when defined, opcodes 1011/1100 SHALL rotate per REQ-015/016.
REQ-024 Without ALU_SHIFT_ROTATE_EN, opcodes 1011/1100 SHALL behave as undefined opcodes (result 0, zero 1, carry 0, REQ-013 latency) and no rotate logic SHALL be built.

Verification (WIDTH=32)
REQ-025 rs=17, rt=3, opCode=0001, start 1 cycle -> done next cycle, result=20, zero=0, carry=0.
REQ-026 rs=3, rt=17, opCode=0010 -> result=0xFFFFFFF2, carry=1; rs=5, rt=5 -> result=0, zero=1.
REQ-027 rs=0x80000000, rt=4, opCode=1010 -> busy 5 cycles, done 5 cycles after start, result=0xF8000000; start pulsed mid-shift ignored.
REQ-028 rs=0x1234, rt=0x20 (amount 0), opCode=1000 -> done 1 cycle later, result=0x1234.
REQ-029 opCode=1001, rs=0xFF, rt=8, reset asserted on 3rd SHIFT cycle -> next cycle IDLE, result=0, zero=1, no done pulse.
REQ-030 rs=0x00000001, rt=1, opCode=1100 -> with ALU_SHIFT_ROTATE_EN result=0x80000000 after 2 cycles; without it result=0 after 1 cycle.
